// File: rtl/ysyx_25020081_ifu_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode output and execute redirect.
interface ysyx_25020081_ifu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_25020081_ifu.sv
// Instruction fetch: one request in flight, 3 cycles/instruction with zero-wait memory.
// Stalls in place on req_ready/rsp_valid/out_ready low; a redirect discards the wrong-path fetch.
module ysyx_25020081_ifu #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ysyx_25020081_ifu_if.master    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  kill_q, kill_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] opc_q, opc_d;
  logic [ADDR_WIDTH-1:0] redir_tgt;

  assign redir_tgt = bus.redirect_pc & ~ADDR_WIDTH'(3);

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = (state_q == S_OUT);
  assign bus.out_inst       = inst_q;
  assign bus.out_pc         = opc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (bus.redirect_valid) pc_d = redir_tgt;
      end
      S_REQ: begin
        if (bus.redirect_valid) pc_d = redir_tgt;
        if (bus.imem_req_ready) begin
          state_d = S_RSP;
          kill_d  = bus.redirect_valid;
        end
      end
      S_RSP: begin
        if (bus.imem_rsp_valid) begin
          if (kill_q || bus.redirect_valid) begin
            // Wrong-path word: drop it and refetch from the (possibly new) pc.
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (bus.redirect_valid) pc_d = redir_tgt;
          end else begin
            inst_d  = bus.imem_rsp_data;
            opc_d   = pc_q;
            state_d = S_OUT;
          end
        end else if (bus.redirect_valid) begin
          kill_d = 1'b1;
          pc_d   = redir_tgt;
        end
      end
      S_OUT: begin
        if (bus.redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end else if (bus.out_ready) begin
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      inst_q  <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
    end
  end

endmodule
